// File: rtl/ia_pingpong_buffer.sv
// Two-bank ping-pong buffer: the producer fills and commits one bank while the consumer
// reads and releases the other. Each bank has a full flag, and refused requests set sticky error bits.
module ia_pingpong_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 128,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_mask,
   input  logic                    wr_commit,
   output logic                    wr_ready,
   output logic                    wr_bank,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   input  logic                    rd_release,
   output logic                    rd_ready,
   output logic                    rd_bank,
   input  logic                    err_clr,
   output logic [1:0]              err
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
   logic [1:0]            full_q, full_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic [1:0]            err_q, err_d;

   logic wr_acc, commit_acc, rd_acc, release_acc;

   assign wr_ready    = !full_q[wr_bank_q];
   assign rd_ready    = full_q[rd_bank_q];
   assign wr_acc      = wr_en && wr_ready;
   assign commit_acc  = wr_commit && wr_ready;
   assign rd_acc      = rd_en && rd_ready;
   assign release_acc = rd_release && rd_ready;

   // Commit targets an empty bank and release a full one, so both may apply in one cycle.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      if (commit_acc) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = !wr_bank_q;
      end
      if (release_acc) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
      if (err_clr) begin
         err_d = '0;
      end else begin
         err_d = err_q | {(rd_en || rd_release) && !rd_ready,
                          (wr_en || wr_commit) && !wr_ready};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= '0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         rd_valid_q <= rd_acc;
         err_q      <= err_d;
         if (rd_acc) begin
            rd_data_q <= mem_q[rd_bank_q][rd_addr];
         end
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (wr_mask[b]) begin
               mem_q[wr_bank_q][wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   assign wr_bank  = wr_bank_q;
   assign rd_bank  = rd_bank_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ia_pingpong_buffer.sv
// Scoreboard bench for ia_pingpong_buffer: stimulus pushes expected read data into a queue,
// and a negedge monitor pops it and compares whenever rd_valid is seen.
module tb_ia_pingpong_buffer;

   localparam int unsigned DW = 32;
   localparam int unsigned DP = 8;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en, wr_commit, wr_ready, wr_bank;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data, rd_data;
   logic [3:0]    wr_mask;
   logic          rd_en, rd_valid, rd_release, rd_ready, rd_bank;
   logic          err_clr;
   logic [1:0]    err;

   int unsigned   total = 0;
   int unsigned   bad   = 0;
   logic [DW-1:0] exp_q [$];

   ia_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .wr_commit(wr_commit), .wr_ready(wr_ready), .wr_bank(wr_bank),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_release(rd_release), .rd_ready(rd_ready), .rd_bank(rd_bank),
      .err_clr(err_clr), .err(err)
   );

   always #5 clk = !clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0; err_clr = 1'b0;
      wr_mask = 4'hF;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected: got rd_valid=1 data=%0h expected no read", rd_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               bad++;
               $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
            end
         end
      end
   end

   initial begin
      idle();
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      rst_n = 1'b0;
      #12;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_banks", {wr_bank, rd_bank}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_err", err, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // read with nothing committed is refused
      rd_en = 1'b1; rd_addr = 3'd1; tick(); idle();
      chk("empty_rd_err", err, 2'b10);
      err_clr = 1'b1; tick(); idle();
      chk("err_clr1", err, 0);

      // fill bank 0 with addr i -> data i, commit, read addr 5
      for (int i = 0; i < int'(DP); i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i); tick();
      end
      idle(); wr_commit = 1'b1; tick(); idle();
      chk("c0_wr_bank", wr_bank, 1);
      chk("c0_rd_ready", rd_ready, 1);
      chk("c0_wr_ready", wr_ready, 1);
      rd_en = 1'b1; rd_addr = 3'd5; exp_q.push_back(32'd5); tick(); idle();
      chk("c0_rd_bank", rd_bank, 0);

      // byte-masked overwrite in bank 1, second write lands in the bank being committed
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hAABBCCDD; tick();
      wr_data = 32'h11223344; wr_mask = 4'b0101; wr_commit = 1'b1; tick(); idle();
      chk("both_full_wr_ready", wr_ready, 0);
      chk("both_full_wr_bank", wr_bank, 0);
      chk("both_full_err", err, 0);

      // refused write into full bank 0
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hDEAD; tick(); idle();
      chk("refused_wr_err", err, 2'b01);
      wr_en = 1'b1; err_clr = 1'b1; tick(); idle();
      chk("err_clr_priority", err, 0);

      // read + release bank 0 in the same cycle returns bank 0 data (write above was ignored)
      rd_en = 1'b1; rd_addr = 3'd0; rd_release = 1'b1; exp_q.push_back(32'd0); tick(); idle();
      chk("rel0_rd_bank", rd_bank, 1);
      chk("rel0_wr_bank", wr_bank, 0);
      chk("rel0_wr_ready", wr_ready, 1);
      chk("rel0_rd_ready", rd_ready, 1);
      rd_en = 1'b1; rd_addr = 3'd3; rd_release = 1'b1; exp_q.push_back(32'hAA22CC44); tick(); idle();
      chk("rel1_rd_ready", rd_ready, 0);
      chk("rel1_rd_bank", rd_bank, 0);
      rd_release = 1'b1; tick(); idle();
      chk("refused_rel_err", err, 2'b10);
      err_clr = 1'b1; tick(); idle();

      // bank 0 filled and committed, then bank 1 filled while bank 0 is read out
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h55; tick(); idle();
      wr_commit = 1'b1; tick(); idle();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h77; tick(); idle();
      rd_en = 1'b1; rd_addr = 3'd1; rd_release = 1'b1; exp_q.push_back(32'h55);
      wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h88; wr_commit = 1'b1; tick(); idle();
      chk("swap_rd_bank", rd_bank, 1);
      chk("swap_wr_bank", wr_bank, 0);
      chk("swap_rd_ready", rd_ready, 1);
      chk("swap_wr_ready", wr_ready, 1);
      chk("swap_err", err, 0);
      rd_en = 1'b1; rd_addr = 3'd2; exp_q.push_back(32'h77); tick();
      rd_addr = 3'd4; exp_q.push_back(32'h88); tick(); idle();
      tick();

      // reset the cycle after an accepted read: no pulse may survive
      rd_en = 1'b1; rd_addr = 3'd2; tick(); idle();
      rst_n = 1'b0; #1;
      chk("mid_rst_rd_valid", rd_valid, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      chk("mid_rst_banks", {wr_bank, rd_bank}, 0);
      chk("mid_rst_readies", {wr_ready, rd_ready}, 2'b10);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) tick();

      for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
